// File: rtl/pcm_sample_fifo_if.sv
// Sample handshake bundle between the I2S receiver, the sample FIFO and the consumer.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface pcm_sample_fifo_if #(
  parameter int DW = 16
);
  logic [DW-1:0] in_data;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;

  modport slave (
    input  in_data, in_vld, out_rdy,
    output in_rdy, out_data, out_vld
  );

  modport master (
    output in_data, in_vld, out_rdy,
    input  in_rdy, out_data, out_vld
  );
endinterface

// File: rtl/pcm_sample_fifo.sv
// First-word-fall-through PCM sample FIFO. The input is never back-pressured:
// samples arriving while full are dropped and tallied in a saturating counter.
module pcm_sample_fifo #(
  parameter  int DW       = 16,
  parameter  int DEPTH    = 16,
  parameter  int AFULL_TH = 12,
  parameter  int OVF_CW   = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  pcm_sample_fifo_if.slave  bus,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [AW:0]       level,
  output logic              almost_full,
  output logic              overflow,
  output logic [OVF_CW-1:0] ovf_cnt
);

  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          in_rdy_reg;
  logic          overflow_reg;
  logic [OVF_CW-1:0] ovf_cnt_reg;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign pop  = ~empty & bus.out_rdy;
  assign push = bus.in_vld & (~full | pop);
  assign drop = bus.in_vld & full & ~pop;

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign almost_full = (level >= AFULL_LVL);
  assign overflow    = overflow_reg;
  assign ovf_cnt     = ovf_cnt_reg;

  assign bus.in_rdy   = in_rdy_reg;
  assign bus.out_vld  = ~empty;
  assign bus.out_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      in_rdy_reg <= 1'b0;
    end else begin
      in_rdy_reg <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // A clear in the same cycle as a drop wins, so that drop goes unrecorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (!(&ovf_cnt_reg)) ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Scoreboard bench for pcm_sample_fifo: a queue model predicts every pop and all
// status outputs on each falling edge, plus directed checks of the key scenarios.
module tb_pcm_sample_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       clr_ovf;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] ovf_cnt;

  pcm_sample_fifo_if #(.DW(DW)) bus ();

  pcm_sample_fifo #(
    .DW(DW), .DEPTH(DEPTH), .AFULL_TH(12), .OVF_CW(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic [7:0]    m_cnt = 8'd0;
  logic          m_rdy = 1'b0;
  logic [DW-1:0] last_pop = '0;

  // Check DUT against the model, then advance the model by what the coming edge will do.
  always @(negedge clk) begin
    logic pop_m, full_m, push_m, drop_m;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 8'd0;
      m_rdy = 1'b0;
      check("rst_level",  32'(level), 32'd0);
      check("rst_out_vld", 32'(bus.out_vld), 32'd0);
      check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
    end else begin
      check("level",       32'(level), 32'(mq.size()));
      check("out_vld",     32'(bus.out_vld), 32'(mq.size() != 0));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
      check("overflow",    32'(overflow), 32'(m_ovf));
      check("ovf_cnt",     32'(ovf_cnt), 32'(m_cnt));
      check("in_rdy",      32'(bus.in_rdy), 32'(m_rdy));
      if (mq.size() != 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));

      pop_m  = (mq.size() != 0) && bus.out_rdy;
      full_m = (mq.size() == DEPTH);
      push_m = bus.in_vld && (!full_m || pop_m);
      drop_m = bus.in_vld && full_m && !pop_m;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop_m)  last_pop = mq.pop_front();
        if (push_m) mq.push_back(bus.in_data);
      end
      if (clr_ovf) begin
        m_ovf = 1'b0;
        m_cnt = 8'd0;
      end else if (drop_m) begin
        m_ovf = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      m_rdy = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    flush       = 1'b0;
    clr_ovf     = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base);
    bus.out_rdy = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.in_data = base + 16'(i);
      bus.in_vld  = 1'b1;
      step();
    end
    bus.in_vld = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.in_data = '0;
    idle();
    repeat (3) step();
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_ovf_cnt",  32'(ovf_cnt), 32'd0);
    check("reset_in_rdy",   32'(bus.in_rdy), 32'd0);
    rst_n = 1'b1;
    step();
    check("in_rdy_after_reset", 32'(bus.in_rdy), 32'd1);

    // Fill and drain
    fill(16'h0000);
    step();
    check("fill_level", 32'(level), 32'd16);
    check("fill_afull", 32'(almost_full), 32'd1);
    bus.out_rdy = 1'b1;
    repeat (DEPTH) step();
    check("drain_last", 32'(last_pop), 32'h0010);
    check("drain_empty", 32'(bus.out_vld), 32'd0);
    bus.out_rdy = 1'b0;
    step();

    // Overflow while full, then clear
    fill(16'h0100);
    bus.in_vld  = 1'b1;
    bus.in_data = 16'hAAAA;
    step();
    bus.in_data = 16'hBBBB;
    step();
    bus.in_vld = 1'b0;
    step();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt2", 32'(ovf_cnt), 32'd2);
    check("ovf_level", 32'(level), 32'd16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_cnt",  32'(ovf_cnt), 32'd0);

    // Full with simultaneous push and pop
    bus.in_vld  = 1'b1;
    bus.in_data = 16'h1234;
    bus.out_rdy = 1'b1;
    step();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    check("pp_level", 32'(level), 32'd16);
    check("pp_nodrop", 32'(ovf_cnt), 32'd0);
    bus.out_rdy = 1'b1;
    repeat (DEPTH) step();
    check("pp_last", 32'(last_pop), 32'h1234);
    check("pp_empty", 32'(bus.out_vld), 32'd0);
    bus.out_rdy = 1'b0;
    step();

    // Latency and stall
    bus.in_vld  = 1'b1;
    bus.in_data = 16'h5A5A;
    check("lat_before", 32'(bus.out_vld), 32'd0);
    step();
    bus.in_vld = 1'b0;
    check("lat_vld", 32'(bus.out_vld), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_data", 32'(bus.out_data), 32'h5A5A);
    end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    check("stall_pop", 32'(last_pop), 32'h5A5A);

    // Saturating drop counter, then flush with push and pop active
    fill(16'h0200);
    bus.in_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_data = 16'($urandom);
      step();
    end
    bus.in_vld = 1'b0;
    step();
    check("sat_cnt", 32'(ovf_cnt), 32'd255);
    flush       = 1'b1;
    bus.in_vld  = 1'b1;
    bus.out_rdy = 1'b1;
    step();
    idle();
    check("flush_level", 32'(level), 32'd0);
    check("flush_vld",   32'(bus.out_vld), 32'd0);
    check("flush_cnt",   32'(ovf_cnt), 32'd255);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;

    // Random stream across pointer wrap, with an asynchronous reset mid-stream
    for (int i = 0; i < 100; i++) begin
      bus.in_vld  = 1'b1;
      bus.in_data = 16'($urandom);
      bus.out_rdy = 1'($urandom_range(0, 1));
      step();
      if (i == 70) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_vld",   32'(bus.out_vld), 32'd0);
        check("async_level", 32'(level), 32'd0);
        step();
        step();
        rst_n = 1'b1;
      end
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (DEPTH + 2) step();
    check("final_empty", 32'(bus.out_vld), 32'd0);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
